fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter CORE, 0, core index; no functional effect beyond instance identification.
REQ-002 Parameter DATA_WIDTH, 32, instruction word width.
REQ-003 Parameter ADDRESS_BITS, 20, PC/address width.
REQ-004 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-005 Port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-007 Port stall  in  1  downstream IF/ID cannot accept; hold current output.
REQ-008 Port branch  in  1  branch condition from decode, as registered by IF/ID.
REQ-009 Port branch_target / JAL_target / JALR_target  in  ADDRESS_BITS each  redirect targets.
REQ-010 Port next_PC_select  in  2  00 sequential, 01 branch, 10 JAL, 11 JALR.
REQ-011 Port i_mem_req  out  1  instruction memory read request.
REQ-012 Port i_mem_addr  out  ADDRESS_BITS  request address.
REQ-013 Port i_mem_ready  in  1  memory accepts request this cycle.
REQ-014 Port i_mem_valid  in  1  read data valid this cycle.
REQ-015 Port i_mem_rdata  in  DATA_WIDTH  read data.
REQ-016 Port instruction  out  DATA_WIDTH  fetched word to IF/ID register.
REQ-017 Port inst_PC  out  ADDRESS_BITS  address of instruction.
REQ-018 Port inst_valid  out  1  instruction/inst_PC hold a real fetched instruction.

Function
REQ-019 Redirect SHALL be true when next_PC_select is 10 or 11, or is 01 with branch=1; select 01 with branch=0 is sequential.
REQ-020 Redirect target SHALL be branch_target (01), JAL_target (10), JALR_target (11); no alignment masking.
REQ-021 Sequential next PC SHALL be PC+4 modulo 2^ADDRESS_BITS (wrap from max to low address, no flag).
REQ-022 FSM states: REQ (i_mem_req=1, i_mem_addr=PC), WAIT (request accepted, awaiting data), HOLD (word captured, stall=1), DROP (awaiting data of a squashed request).
REQ-023 REQ -> WAIT on i_mem_ready=1; remains REQ otherwise.
REQ-024 WAIT on i_mem_valid=1: capture i_mem_rdata to instruction, PC to inst_PC, inst_valid=1; if stall=0 advance PC and go REQ, else go HOLD.
REQ-025 HOLD: outputs frozen; on stall=0 advance PC, go REQ.
REQ-026 Redirect in REQ or HOLD: PC <= target, go REQ, inst_valid <= 0, instruction <= 0x00000013 (NOP) next cycle.
REQ-027 Redirect in WAIT with i_mem_valid=0: PC <= target, go DROP; in WAIT with i_mem_valid=1: data discarded, PC <= target, go REQ.
REQ-028 DROP: i_mem_req=0; on i_mem_valid=1 discard data, go REQ; a further redirect in DROP updates PC only.
REQ-029 Redirect SHALL take priority over stall and over sequential advance in the same cycle.
REQ-030 inst_valid SHALL be 0 and instruction SHALL be NOP in every cycle no new word is delivered and stall=0.
REQ-031 Minimum latency: request accepted cycle N, data at N+1, instruction valid at N+2; sustained rate one instruction per two cycles with zero-wait memory.
REQ-032 i_mem_req SHALL be asserted only in REQ; i_mem_addr stable while i_mem_req=1 and i_mem_ready=0.

Reset
REQ-033 While reset=0 at a rising edge: PC=RESET_PC, state=REQ, instruction=NOP, inst_PC=RESET_PC, inst_valid=0.
REQ-034 Reset mid-WAIT SHALL abandon the request; the late response is ignored because state REQ does not sample i_mem_valid.
REQ-035 First request SHALL issue in the first cycle after reset returns to 1.

Structure
REQ-036 State encoding, NOP constant (0x00000013) and next_PC_select encodings SHALL live in a shared package.
REQ-037 One sub-module next_pc_sel (combinational redirect decode and target mux) is natural; FSM and registers stay in fetch_unit.

Verification
REQ-038 Reset, zero-wait memory returning word=PC: inst_PC sequence 0,4,8 with inst_valid every other cycle.
REQ-039 i_mem_ready held 0 for 3 cycles: i_mem_addr stable at 0x00004 throughout, one request only.
REQ-040 JAL select=10, target 0x00100 while WAIT: response for old PC discarded (DROP), next request at 0x00100, NOP emitted.
REQ-041 Stall=1 for 4 cycles after valid word at 0x00008: outputs frozen, no new request; resumes at 0x0000C.
REQ-042 PC=0xFFFFC sequential: next request at 0x00000; select=01 with branch=0: sequential, no squash.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding
//   pc_sel_t      : next_PC_select encodings from decode
//   NOP_INSTR     : word presented to IF/ID when no instruction is delivered
//   PC_STEP       : byte distance between sequential instructions
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JAL    = 2'b10,
        SEL_JALR   = 2'b11
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Redirect decode and target mux for the fetch unit (purely combinational).
// Ports:
//   i_branch         branch condition from decode
//   i_next_pc_select 00 seq, 01 branch, 10 JAL, 11 JALR
//   i_branch_target / i_jal_target / i_jalr_target  candidate targets
//   o_redirect       PC must be redirected this cycle
//   o_target         redirect target (no alignment masking)
module fetch_unit_next_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    i_branch,
    input  logic [1:0]              i_next_pc_select,
    input  logic [ADDRESS_BITS-1:0] i_branch_target,
    input  logic [ADDRESS_BITS-1:0] i_jal_target,
    input  logic [ADDRESS_BITS-1:0] i_jalr_target,
    output logic                    o_redirect,
    output logic [ADDRESS_BITS-1:0] o_target
);

    always_comb begin
        o_redirect = 1'b0;
        o_target   = i_branch_target;
        case (pc_sel_t'(i_next_pc_select))
            SEL_SEQ: begin
                o_redirect = 1'b0;
            end
            // A not-taken branch is plain sequential flow
            SEL_BRANCH: begin
                o_redirect = i_branch;
                o_target   = i_branch_target;
            end
            SEL_JAL: begin
                o_redirect = 1'b1;
                o_target   = i_jal_target;
            end
            SEL_JALR: begin
                o_redirect = 1'b1;
                o_target   = i_jalr_target;
            end
            default: begin
                o_redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// delivers the returned word to the IF/ID register and handles redirects.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   stall               IF/ID cannot accept; hold presented instruction
//   branch, branch_target, JAL_target, JALR_target, next_PC_select
//                       redirect controls from decode
//   i_mem_req/addr      read request (only in REQ), i_mem_ready handshake
//   i_mem_valid/rdata   read response
//   instruction, inst_PC, inst_valid   word presented to IF/ID
//
// state | meaning
// REQ   | request asserted at PC, waiting for i_mem_ready
// WAIT  | request accepted, waiting for i_mem_valid
// HOLD  | word captured while stalled, outputs frozen
// DROP  | waiting for the response of a squashed request
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      CORE         = 0,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic [1:0]              next_PC_select,
    output logic                    i_mem_req,
    output logic [ADDRESS_BITS-1:0] i_mem_addr,
    input  logic                    i_mem_ready,
    input  logic                    i_mem_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    inst_valid
);

    localparam logic [DATA_WIDTH-1:0]   NOP_WORD = DATA_WIDTH'(NOP_INSTR);
    localparam logic [ADDRESS_BITS-1:0] PC_INC   = ADDRESS_BITS'(PC_STEP);

    // CORE only names the instance; it has no effect on the logic.
    if (CORE < 0) begin : g_core_index_negative
    end

    fetch_state_t              r_state, w_state_next;
    logic [ADDRESS_BITS-1:0]   r_pc, w_pc_next;
    logic [DATA_WIDTH-1:0]     r_instr, w_instr_next;
    logic [ADDRESS_BITS-1:0]   r_inst_pc, w_inst_pc_next;
    logic                      r_inst_valid, w_inst_valid_next;
    logic                      w_redirect;
    logic [ADDRESS_BITS-1:0]   w_target;
    logic [ADDRESS_BITS-1:0]   w_pc_seq;

    fetch_unit_next_pc_sel #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_next_pc_sel (
        .i_branch         (branch),
        .i_next_pc_select (next_PC_select),
        .i_branch_target  (branch_target),
        .i_jal_target     (JAL_target),
        .i_jalr_target    (JALR_target),
        .o_redirect       (w_redirect),
        .o_target         (w_target)
    );

    // Wraps modulo 2^ADDRESS_BITS by construction
    assign w_pc_seq = r_pc + PC_INC;

    assign i_mem_req   = (r_state == ST_REQ);
    assign i_mem_addr  = r_pc;
    assign instruction = r_instr;
    assign inst_PC     = r_inst_pc;
    assign inst_valid  = r_inst_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_WORD;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_inst_pc    <= w_inst_pc_next;
            r_inst_valid <= w_inst_valid_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_inst_pc_next    = r_inst_pc;
        w_inst_valid_next = r_inst_valid;

        if (w_redirect) begin
            // Redirect wins over stall and sequential advance; any word in
            // flight or held belongs to the wrong path.
            w_pc_next         = w_target;
            w_instr_next      = NOP_WORD;
            w_inst_valid_next = 1'b0;
            case (r_state)
                ST_WAIT, ST_DROP: w_state_next = i_mem_valid ? ST_REQ : ST_DROP;
                default:          w_state_next = ST_REQ;
            endcase
        end else begin
            // Once downstream has taken the word, present a bubble
            if (!stall) begin
                w_instr_next      = NOP_WORD;
                w_inst_valid_next = 1'b0;
            end
            case (r_state)
                ST_REQ: begin
                    if (i_mem_ready) begin
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_valid) begin
                        w_instr_next      = i_mem_rdata;
                        w_inst_pc_next    = r_pc;
                        w_inst_valid_next = 1'b1;
                        if (stall) begin
                            w_state_next = ST_HOLD;
                        end else begin
                            w_pc_next    = w_pc_seq;
                            w_state_next = ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_pc_next    = w_pc_seq;
                        w_state_next = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (i_mem_valid) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: begin
                    w_state_next = ST_REQ;
                end
            endcase
        end
    end

endmodule
